// File: rtl/n101_uartrx_pkg.sv
// Shared constants for the n101 UART receive controller: FSM encodings and
// default sizing for the byte FIFO and idle timeout.
package n101_uartrx_pkg;

  localparam logic [1:0] ST_OFF    = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_RESYNC = 2'd2;

  localparam int unsigned DEPTH_DEF      = 8;
  localparam int unsigned TO_BITS_DEF    = 32;
  localparam int unsigned RESYNC_CYC_DEF = 2;

endpackage

// File: rtl/n101_uartrx_ctrl_if.sv
// Receiver-side and register-file-side handshake of the n101 UART receive
// controller; the controller takes the slave view, its environment the master view.
interface n101_uartrx_ctrl_if;

  logic        rx_en;
  logic [15:0] rx_div;
  logic        rx_valid;
  logic [7:0]  rx_bits;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic        rd_pop;

  modport slave (
    output rx_en, rx_div, rd_valid, rd_data,
    input  rx_valid, rx_bits, rd_pop
  );

  modport master (
    input  rx_en, rx_div, rd_valid, rd_data,
    output rx_valid, rx_bits, rd_pop
  );

endinterface

// File: rtl/n101_uartrx_fifo.sv
// DEPTH x 8 first-word-fall-through byte FIFO with push/pop/flush. Occupancy
// is the full/empty discriminator, so both pointers simply wrap.
module n101_uartrx_fifo
  import n101_uartrx_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned LW   = AW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push_i,
  input  logic [7:0]    data_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output logic [7:0]    head_o,
  output logic [LW-1:0] level_o,
  output logic [LW-1:0] level_next_o,
  output logic          empty_o,
  output logic          drop_o
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          full, pop_ok, push_ok;

  assign empty_o = (level_q == '0);
  assign full    = (level_q == LW'(DEPTH));
  assign pop_ok  = pop_i & ~empty_o;
  // A pop on a full FIFO frees the slot the same-cycle push lands in.
  assign push_ok = push_i & (~full | pop_ok);
  assign drop_o  = push_i & ~push_ok & ~flush_i;

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push_ok && !pop_ok)      level_d = level_q + 1'b1;
      else if (pop_ok && !push_ok) level_d = level_q - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // NOTE: storage is deliberately not reset; the head is masked to zero while empty instead.
  always_ff @(posedge clock) begin
    if (push_ok && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o       = empty_o ? 8'h00 : mem_q[rd_ptr_q];
  assign level_o      = level_q;
  assign level_next_o = level_d;

endmodule

// File: rtl/n101_uartrx_ctrl.sv
// n101 UART receive controller: enable/divisor sequencing with forced resync,
// receive byte FIFO, watermark/idle-timeout/overflow indications.
module n101_uartrx_ctrl
  import n101_uartrx_pkg::*;
#(
  parameter int unsigned DEPTH      = DEPTH_DEF,
  parameter int unsigned TO_BITS    = TO_BITS_DEF,
  parameter int unsigned RESYNC_CYC = RESYNC_CYC_DEF
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     cfg_en,
  input  logic [15:0]              cfg_div,
  input  logic                     cfg_div_we,
  input  logic [$clog2(DEPTH)-1:0] cfg_wm,
  input  logic                     cfg_flush,
  input  logic                     ovf_clr,
  n101_uartrx_ctrl_if.slave        bus,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     irq_wm,
  output logic                     irq_to,
  output logic                     ovf
);

  localparam int unsigned RW = (RESYNC_CYC > 1) ? $clog2(RESYNC_CYC) : 1;
  localparam int unsigned BW = $clog2(TO_BITS + 1);
  localparam logic [RW-1:0] RLOAD = RW'(RESYNC_CYC - 1);

  logic [1:0]             state_q, state_d;
  logic [RW-1:0]          rcnt_q, rcnt_d;
  logic [15:0]            rx_div_q, div_eff;
  logic [15:0]            cyc_q, cyc_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic                   irq_wm_q, ovf_q, ovf_d, to_clr;
  logic                   fifo_empty, fifo_drop;
  logic [$clog2(DEPTH):0] level_nxt;

  n101_uartrx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock        (clock),
    .reset        (reset),
    .push_i       (bus.rx_valid),
    .data_i       (bus.rx_bits),
    .pop_i        (bus.rd_pop),
    .flush_i      (cfg_flush),
    .head_o       (bus.rd_data),
    .level_o      (level),
    .level_next_o (level_nxt),
    .empty_o      (fifo_empty),
    .drop_o       (fifo_drop)
  );

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    case (state_q)
      ST_OFF: if (cfg_en) state_d = ST_RUN;
      ST_RUN: begin
        if (!cfg_en) state_d = ST_OFF;
        else if (cfg_div_we) begin
          state_d = ST_RESYNC;
          rcnt_d  = RLOAD;
        end
      end
      ST_RESYNC: begin
        if (!cfg_en)           state_d = ST_OFF;
        else if (cfg_div_we)   rcnt_d  = RLOAD;
        else if (rcnt_q == '0) state_d = ST_RUN;
        else                   rcnt_d  = rcnt_q - 1'b1;
      end
      default: state_d = ST_OFF;
    endcase
  end

  // A zero divisor would never wrap the bit-time counter; run it at one cycle per bit.
  assign div_eff = (rx_div_q == 16'h0) ? 16'h1 : rx_div_q;
  assign to_clr  = bus.rx_valid | (bus.rd_pop & bus.rd_valid) | fifo_empty
                 | cfg_flush | (state_q != ST_RUN);

  always_comb begin
    cyc_d = cyc_q;
    bit_d = bit_q;
    if (to_clr) begin
      cyc_d = '0;
      bit_d = '0;
    end else if (cyc_q == div_eff - 16'd1) begin
      cyc_d = '0;
      if (bit_q != BW'(TO_BITS)) bit_d = bit_q + 1'b1;
    end else begin
      cyc_d = cyc_q + 16'd1;
    end
  end

  // A fresh overflow outranks a same-cycle clear.
  assign ovf_d = fifo_drop | (ovf_q & ~ovf_clr);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_OFF;
      rcnt_q   <= '0;
      rx_div_q <= '0;
      cyc_q    <= '0;
      bit_q    <= '0;
      irq_wm_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rcnt_q   <= rcnt_d;
      if (cfg_div_we) rx_div_q <= cfg_div;
      cyc_q    <= cyc_d;
      bit_q    <= bit_d;
      irq_wm_q <= (level_nxt > {1'b0, cfg_wm});
      ovf_q    <= ovf_d;
    end
  end

  assign bus.rx_en    = (state_q == ST_RUN);
  assign bus.rx_div   = rx_div_q;
  assign bus.rd_valid = ~fifo_empty;
  assign irq_wm       = irq_wm_q;
  assign irq_to       = (bit_q == BW'(TO_BITS));
  assign ovf          = ovf_q;

endmodule
